ntt_wb_addr_gen: RTL and testbench
==================================

NTT_WB_ADDR_GEN -- requirements
Module: ntt_wb_addr_gen

Interface
REQ-001 Parameter LANES, default 8, number of coefficients written per group.
REQ-002 Parameter N_GROUPS, default 8, number of groups per stage; must be a power of two.
REQ-003 Parameter N_STAGES, default 6, number of stages per transform.
REQ-004 Parameter W, default 16, coefficient width.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 start  input  1  one-cycle request to begin a transform; honoured only in IDLE.
REQ-008 bank_base  input  10  write base address; latched on an accepted start.
REQ-009 in_valid  input  1  a butterfly result group is present on in_data.
REQ-010 in_ready  output  1  the block accepts in_data this cycle.
REQ-011 in_data  input  LANES*W  result group; lane m occupies bits [m*W +: W].
REQ-012 out_valid  output  1  the write group on wr_addr and wr_data is valid.
REQ-013 out_ready  input  1  the memory side accepts the write group.
REQ-014 wr_addr  output  LANES*10  new_address per lane; lane m occupies bits [m*10 +: 10].
REQ-015 wr_data  output  LANES*W  registered copy of the accepted in_data.
REQ-016 stage_J  output  10  stride of the current stage: 1, 2, 4, ... 2^(N_STAGES-1).
REQ-017 busy  output  1  high in RUN and DRAIN.
REQ-018 done  output  1  one-cycle pulse after the final group's write handshake.

Function
REQ-019 FSM states: IDLE, RUN, DRAIN.
- IDLE->RUN on start; latch bank_base; g=0; stage_J=1.
- RUN->DRAIN when the last group of the last stage is accepted.
- DRAIN->IDLE on the out handshake; done is pulsed in that same cycle.
REQ-020 Input acceptance occurs when in_valid && in_ready; in_ready = (state==RUN) && (!out_valid || out_ready).
REQ-021 Output latency: an accepted group appears on the outputs with out_valid=1 on the next cycle; there is a single output register and no FIFO.
REQ-022 out_valid clears on an out handshake with no new acceptance, and stays set when a new acceptance coincides with the handshake (back-to-back throughput of 1 group per cycle).
REQ-023 wr_addr, wr_data and out_valid hold stable while out_valid && !out_ready.
REQ-024 Address of lane m for group g: (base + g*LANES + m) mod 1024, using 10-bit wrap-around arithmetic.
REQ-025 Group counter g increments on each acceptance and wraps from N_GROUPS-1 to 0.
REQ-026 On that wrap, stage_J doubles.
REQ-027 After the stage-(N_STAGES-1) wrap, no further input is accepted.
REQ-028 stage_J remains at its final value in DRAIN, returns to 1 in IDLE, and reads 1 in IDLE.
REQ-029 start is ignored outside IDLE.
REQ-030 When start and in_valid occur in the same IDLE cycle, no data is accepted that cycle.
REQ-031 done is 0 except for the single pulse; busy = (state != IDLE).

Reset
REQ-032 On rst_n low, at any time including mid-transform:
- state=IDLE, g=0, stage_J=1, base=0;
- out_valid=0, in_ready=0, done=0, busy=0;
- wr_addr=0, wr_data=0.
REQ-033 No partially accepted group survives reset, and no write handshake occurs until a new start.

Structure
REQ-034 Shared package ntt_pkg holds:
- ADDR_W=10, the FSM state enum, default LANES/N_GROUPS/N_STAGES/W;
- the lane-address function shared with the read-side address generator.
REQ-035 One sub-module, ntt_wb_lane_addr, computes the per-lane address (base, g, m -> 10-bit address), instantiated LANES times.
REQ-036 Counters, FSM and output register live in the top module.

Verification
REQ-037 Streaming: start with base=0; in_valid and out_ready held high; 48 groups.
- Expect 48 consecutive out_valid cycles; group 0 lanes get addresses 0..7 and group 7 gets 56..63.
- stage_J steps through 1, 2, 4, 8, 16, 32.
- done is high exactly one cycle after the 48th handshake.
REQ-038 Backpressure: out_ready=0 for 5 cycles after the first output.
- in_ready stays 0 and the outputs hold unchanged.
- After release, data arrives in order with none lost or duplicated.
REQ-039 Wrap-around: base=1020. Expect group 0 addresses 1020, 1021, 1022, 1023, 0, 1, 2, 3.
REQ-040 Reset mid-transform: assert rst_n=0 after group 20. Expect all outputs at reset values.
- A new start with base=0 yields group-0 addresses 0..7 and stage_J=1.
REQ-041 Protocol corners:
- start pulsed during RUN: no effect.
- in_valid in IDLE: in_ready=0 and nothing accepted.
- start and in_valid in the same cycle: no acceptance that cycle.

Source files
------------

// File: rtl/ntt_pkg.sv
// rtl/ntt_pkg.sv - shared NTT address-generation definitions
// Provides the address width, default geometry, FSM state encoding and the
// lane-address function used by both the read- and write-side generators.
package ntt_pkg;

    localparam int ADDR_W       = 10;
    localparam int DEF_LANES    = 8;
    localparam int DEF_N_GROUPS = 8;
    localparam int DEF_N_STAGES = 6;
    localparam int DEF_W        = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } ntt_state_e;

    // (base + g*lanes + m) with 10-bit wrap-around; truncation does the mod 1024.
    function automatic logic [ADDR_W-1:0] lane_addr(
        input logic [ADDR_W-1:0] base,
        input logic [ADDR_W-1:0] g,
        input logic [ADDR_W-1:0] m,
        input int                lanes
    );
        logic [ADDR_W-1:0] stride;
        stride = ADDR_W'(lanes);
        return base + g * stride + m;
    endfunction

endpackage

// File: rtl/ntt_wb_lane_addr.sv
// rtl/ntt_wb_lane_addr.sv - per-lane write-back address
// Ports:
//   base_i  - latched bank base address
//   g_i     - current group index
//   m_i     - lane index within the group
//   addr_o  - 10-bit wrapped write address for this lane
module ntt_wb_lane_addr
    import ntt_pkg::*;
#(
    parameter int LANES = DEF_LANES
) (
    input  logic [ADDR_W-1:0] base_i,
    input  logic [ADDR_W-1:0] g_i,
    input  logic [ADDR_W-1:0] m_i,
    output logic [ADDR_W-1:0] addr_o
);

    assign addr_o = lane_addr(base_i, g_i, m_i, LANES);

endmodule

// File: rtl/ntt_wb_addr_gen.sv
// rtl/ntt_wb_addr_gen.sv - NTT butterfly write-back address generator
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   start, bank_base     - begin a transform at the given base address (IDLE only)
//   in_valid/in_ready    - butterfly result group handshake, in_data payload
//   out_valid/out_ready  - write group handshake, wr_addr/wr_data payload
//   stage_J              - stride of the current stage (1,2,4,...)
//   busy, done           - transform in progress, one-cycle completion pulse
module ntt_wb_addr_gen
    import ntt_pkg::*;
#(
    parameter int LANES    = DEF_LANES,
    parameter int N_GROUPS = DEF_N_GROUPS,
    parameter int N_STAGES = DEF_N_STAGES,
    parameter int W        = DEF_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        bank_base,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*W-1:0]       in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*ADDR_W-1:0]  wr_addr,
    output logic [LANES*W-1:0]       wr_data,
    output logic [ADDR_W-1:0]        stage_J,
    output logic                     busy,
    output logic                     done
);

    localparam int G_W = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1;
    localparam logic [G_W-1:0]    G_LAST = G_W'(N_GROUPS - 1);
    localparam logic [ADDR_W-1:0] J_LAST = ADDR_W'(1 << (N_STAGES - 1));

    ntt_state_e              state_q;
    logic [G_W-1:0]          g_q;
    logic [ADDR_W-1:0]       base_q;
    logic [ADDR_W-1:0]       stage_j_q;
    logic                    out_valid_q;
    logic                    done_q;
    logic [LANES*ADDR_W-1:0] wr_addr_q;
    logic [LANES*W-1:0]      wr_data_q;
    logic [LANES*ADDR_W-1:0] lane_addr_w;
    logic                    accept;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        ntt_wb_lane_addr #(.LANES(LANES)) u_lane_addr (
            .base_i (base_q),
            .g_i    (ADDR_W'(g_q)),
            .m_i    (ADDR_W'(i)),
            .addr_o (lane_addr_w[i*ADDR_W +: ADDR_W])
        );
    end

    // A new group may enter whenever the single output slot is free or draining now.
    assign in_ready  = (state_q == ST_RUN) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign stage_J   = stage_j_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            g_q         <= '0;
            base_q      <= '0;
            stage_j_q   <= ADDR_W'(1);
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q   <= ST_RUN;
                        base_q    <= bank_base;
                        g_q       <= '0;
                        stage_j_q <= ADDR_W'(1);
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        out_valid_q <= 1'b1;
                        wr_addr_q   <= lane_addr_w;
                        wr_data_q   <= in_data;
                        if (g_q == G_LAST) begin
                            g_q <= '0;
                            // The final stage's wrap ends input; stride keeps its last value.
                            if (stage_j_q == J_LAST) begin
                                state_q <= ST_DRAIN;
                            end else begin
                                stage_j_q <= stage_j_q << 1;
                            end
                        end else begin
                            g_q <= g_q + 1'b1;
                        end
                    end else if (out_valid_q && out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                        done_q      <= 1'b1;
                        stage_j_q   <= ADDR_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ntt_wb_addr_gen.sv
// tb/tb_ntt_wb_addr_gen.sv - self-checking bench for ntt_wb_addr_gen
module tb_ntt_wb_addr_gen;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [9:0]   bank_base;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [79:0]  wr_addr;
    logic [127:0] wr_data;
    logic [9:0]   stage_J;
    logic         busy;
    logic         done;

    ntt_wb_addr_gen dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bank_base (bank_base),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .stage_J   (stage_J),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // reference model
    int   m_state, m_g, m_j, m_base, m_acc;
    bit   m_ov, m_done;
    logic [79:0]  sb_addr[$];
    logic [127:0] sb_data[$];
    logic [79:0]  obs_addr[$];
    int   cyc, last_hs_cyc, done_cyc, done_cnt, run, max_run;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic exp_rdy, acc, hs;
        logic [79:0] ea;
        bit nd;
        in_data = {$urandom, $urandom, $urandom, $urandom};
        #1;
        cyc++;
        if (!rst_n) begin
            m_state = 0; m_ov = 0; m_done = 0; m_j = 1; m_g = 0;
            sb_addr.delete(); sb_data.delete();
            chk("rst_out_valid", 128'(out_valid), 128'(0));
            chk("rst_in_ready",  128'(in_ready),  128'(0));
            chk("rst_done",      128'(done),      128'(0));
            chk("rst_busy",      128'(busy),      128'(0));
            chk("rst_stage_J",   128'(stage_J),   128'(1));
            chk("rst_wr_addr",   128'(wr_addr),   128'(0));
            chk("rst_wr_data",   wr_data,         128'(0));
        end else begin
            exp_rdy = (m_state == 1) && (!m_ov || out_ready);
            chk("in_ready",  128'(in_ready),  128'(exp_rdy));
            chk("out_valid", 128'(out_valid), 128'(m_ov));
            chk("busy",      128'(busy),      128'(m_state != 0));
            chk("done",      128'(done),      128'(m_done));
            chk("stage_J",   128'(stage_J),   128'(m_j));
            if (m_ov) begin
                if (sb_addr.size() == 0) chk("sb_empty", 128'(1), 128'(0));
                else begin
                    chk("wr_addr", 128'(wr_addr), 128'(sb_addr[0]));
                    chk("wr_data", wr_data, sb_data[0]);
                end
            end
            acc = exp_rdy && in_valid;
            hs  = m_ov && out_ready;
            if (out_valid && out_ready) last_hs_cyc = cyc;
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (out_valid) run++;
            else begin if (run > max_run) max_run = run; run = 0; end
            if (hs) begin
                obs_addr.push_back(wr_addr);
                if (sb_addr.size() > 0) begin
                    void'(sb_addr.pop_front());
                    void'(sb_data.pop_front());
                end
            end
            nd = 0;
            case (m_state)
                0: if (start) begin m_state = 1; m_base = int'(bank_base); m_g = 0; m_j = 1; end
                1: begin
                    if (acc) begin
                        for (int m = 0; m < 8; m++)
                            ea[m*10 +: 10] = 10'((m_base + m_g * 8 + m) % 1024);
                        sb_addr.push_back(ea);
                        sb_data.push_back(in_data);
                        m_ov = 1; m_acc++;
                        if (m_g == 7) begin
                            m_g = 0;
                            if (m_j == 32) m_state = 2; else m_j = m_j * 2;
                        end else m_g++;
                    end else if (hs) m_ov = 0;
                end
                default: if (out_ready) begin m_ov = 0; m_state = 0; nd = 1; m_j = 1; end
            endcase
            m_done = nd;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_stats();
        obs_addr.delete(); done_cnt = 0; run = 0; max_run = 0; m_acc = 0;
    endtask

    task automatic run_to_idle(input string tag, input bit rand_hs);
        int k;
        for (k = 0; k < 1000 && m_state != 0; k++) begin
            if (rand_hs) begin
                in_valid  = 1'($urandom_range(0, 1));
                out_ready = 1'($urandom_range(0, 1));
            end
            tick();
        end
        if (m_state != 0) chk({tag, "_timeout"}, 128'(k), 128'(0));
        in_valid = 1'b1; out_ready = 1'b1;
        tick();  // done pulse cycle
        tick();
    endtask

    initial begin
        logic [79:0] a;
        int wrap_tab[8] = '{1020, 1021, 1022, 1023, 0, 1, 2, 3};
        cyc = 0; last_hs_cyc = -1; done_cyc = -1;
        m_state = 0; m_ov = 0; m_done = 0; m_j = 1; m_g = 0; m_base = 0;
        rst_n = 1'b0; start = 1'b0; bank_base = '0; in_valid = 1'b0; out_ready = 1'b1;
        in_data = '0;
        @(negedge clk);
        tick(); tick();
        rst_n = 1'b1;

        // in_valid while idle: nothing accepted
        in_valid = 1'b1;
        tick(); tick();

        // streaming, base 0; start coincides with in_valid
        clear_stats();
        start = 1'b1; bank_base = 10'd0;
        tick();
        start = 1'b0;
        chk("stream_J_first", 128'(stage_J), 128'(1));
        for (int k = 0; k < 12; k++) tick();
        start = 1'b1; bank_base = 10'd500;  // ignored in RUN
        tick();
        start = 1'b0;
        for (int k = 0; k < 200 && m_state != 2; k++) tick();
        chk("drain_J", 128'(stage_J), 128'(32));
        run_to_idle("stream", 1'b0);
        chk("stream_hs",   128'(obs_addr.size()), 128'(48));
        chk("stream_run",  128'(max_run), 128'(48));
        chk("stream_done_cnt", 128'(done_cnt), 128'(1));
        chk("stream_done_lat", 128'(done_cyc), 128'(last_hs_cyc + 1));
        a = (obs_addr.size() > 0) ? obs_addr[0] : 'x;
        for (int m = 0; m < 8; m++) chk("g0_lane", 128'(a[m*10 +: 10]), 128'(m));
        a = (obs_addr.size() > 7) ? obs_addr[7] : 'x;
        for (int m = 0; m < 8; m++) chk("g7_lane", 128'(a[m*10 +: 10]), 128'(56 + m));

        // backpressure, base 100
        clear_stats();
        out_ready = 1'b0; start = 1'b1; bank_base = 10'd100;
        tick();
        start = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) tick();
        out_ready = 1'b1;
        run_to_idle("bp", 1'b1);
        chk("bp_hs", 128'(obs_addr.size()), 128'(48));
        chk("bp_sb_left", 128'(sb_addr.size()), 128'(0));

        // address wrap-around, base 1020
        clear_stats();
        start = 1'b1; bank_base = 10'd1020;
        tick();
        start = 1'b0;
        run_to_idle("wrap", 1'b0);
        a = (obs_addr.size() > 0) ? obs_addr[0] : 'x;
        for (int m = 0; m < 8; m++) chk("wrap_lane", 128'(a[m*10 +: 10]), 128'(wrap_tab[m]));

        // reset mid-transform after group 20
        clear_stats();
        start = 1'b1; bank_base = 10'd0;
        tick();
        start = 1'b0;
        for (int k = 0; k < 100 && m_acc < 21; k++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick(); tick();
        clear_stats();
        start = 1'b1; bank_base = 10'd0;
        tick();
        start = 1'b0;
        chk("restart_J", 128'(stage_J), 128'(1));
        run_to_idle("restart", 1'b0);
        a = (obs_addr.size() > 0) ? obs_addr[0] : 'x;
        for (int m = 0; m < 8; m++) chk("restart_lane", 128'(a[m*10 +: 10]), 128'(m));
        chk("restart_hs", 128'(obs_addr.size()), 128'(48));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
